ecp5pll_phase_ctrl: RTL and testbench
=====================================

ECP5PLL_PHASE_CTRL -- requirements
Module: ecp5pll_phase_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter SETUP_CYC, default 4: cycles phasesel/phasedir are held stable before the first pulse (range 1..255).
REQ-003 Parameter PULSE_CYC, default 4: phasestep/phaseloadreg high time in cycles (range 1..255).
REQ-004 Parameter GAP_CYC, default 8: phasestep low time after each pulse in cycles (range 1..255).
REQ-005 Parameter LOCK_WAIT, default 1: 1 = hold a pending pulse while locked is 0.
REQ-006 Port clk_i  in  1  clock; the same clock drives the PLL dynamic-phase pins.
REQ-007 Port reset  in  1  synchronous active-high reset.
REQ-008 Port cmd_valid  in  1  command offered.
REQ-009 Port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-010 Port cmd_sel  in  2  output channel 0..3 (0=CLKOP, 1..3=CLKOS..CLKOS3), same numbering as the PLL wrapper phasesel.
REQ-011 Port cmd_dir  in  1  0 = step +1 (lag), 1 = step -1 (lead).
REQ-012 Port cmd_load  in  1  1 = phaseloadreg command (cmd_dir and cmd_steps are ignored).
REQ-013 Port cmd_steps  in  8  number of 1/8-VCO-period steps; 0 = no-op.
REQ-014 Port locked  in  1  PLL lock indicator.
REQ-015 Ports phasesel (out, 2), phasedir (out, 1), phasestep (out, 1), phaseloadreg (out, 1) drive the PLL dynamic-phase pins.
REQ-016 Port busy  out  1  high in every state other than IDLE.
REQ-017 Port done  out  1  one-cycle pulse at command completion.
REQ-018 Port phase_o  out  40  four 10-bit step accumulators; channel k occupies bits [10k+9:10k].

Function
REQ-019 The state machine SHALL have the states IDLE, SETUP, PULSE, GAP, LOCKWAIT and DONE.
REQ-020 cmd_ready SHALL be 1 only in IDLE; commands offered in any other state are ignored.
REQ-021 On acceptance, the block SHALL latch sel, dir, load and steps, drive phasesel=sel and phasedir=dir from the next cycle, and hold both stable until the block returns to IDLE.
REQ-022 Step timing, with the acceptance edge as cycle 0:
  - SETUP occupies cycles 1..SETUP_CYC.
  - Each step is PULSE_CYC cycles with phasestep=1, then GAP_CYC cycles with phasestep=0.
  - done=1 at cycle SETUP_CYC+N*(PULSE_CYC+GAP_CYC)+1.
  - cmd_ready returns to 1 on the following cycle.
REQ-023 On entering PULSE, accumulator[sel] SHALL be incremented by 1 (dir=0) or decremented by 1 (dir=1), modulo 1024: 1023+1 gives 0, 0-1 gives 1023.
REQ-024 A load command SHALL produce one phaseloadreg pulse of PULSE_CYC cycles, then GAP, then DONE, and SHALL clear accumulator[sel] on entering PULSE; phasestep stays 0.
REQ-025 A command with cmd_steps=0 and cmd_load=0 SHALL go directly to DONE on the cycle after acceptance, with no pulse and no change to any accumulator.
REQ-026 When LOCK_WAIT=1 and locked=0 at the point of entering PULSE, the block SHALL enter LOCKWAIT with phasestep=0 and SHALL go to PULSE on the cycle after locked is sampled 1.
REQ-027 A pulse already in progress SHALL never be truncated, regardless of changes on locked.
REQ-028 At most one of phasestep and phaseloadreg SHALL be high in any cycle.

Reset
REQ-029 While reset is high, all outputs SHALL be 0: phasesel, phasedir, phasestep, phaseloadreg, busy, done, cmd_ready, and phase_o.
REQ-030 Reset SHALL set the state to IDLE, and cmd_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-031 A reset asserted mid-command SHALL abort the command, force phasestep to 0 at that edge, and produce no done pulse.

Structure
REQ-032 Package ecp5pll_pkg SHALL hold the state enum, the channel-index typedef (2-bit), the accumulator width constant (10), and the default timing constants.
REQ-033 A single sub-module ecp5pll_pulse_timer (a loadable down-counter with a zero flag) SHALL be used for the SETUP, PULSE and GAP intervals.

Verification
REQ-034 Stepping: reset, then sel=2, dir=0, steps=3 -> three phasestep pulses of 4 cycles each at cycles 5, 17 and 29; done at cycle 41; phase_o[29:20]=3; phasesel=2 for cycles 1..41.
REQ-035 Wrap-around: sel=1, dir=1, steps=1 from a zero accumulator -> phase_o[19:10]=1023; then dir=0, steps=2 -> 1.
REQ-036 Load and no-op: load with sel=1 -> one 4-cycle phaseloadreg pulse and phase_o[19:10]=0; steps=0 -> done at cycle 1 with no pulse.
REQ-037 Lock wait: locked=0 at cycle 4, steps=1 -> phasestep stays 0 until 1 cycle after locked rises at cycle 20, then pulses at cycle 21.
REQ-038 Busy and reset: cmd_valid held high during busy -> no second accept; reset at cycle 10 of a 3-step command -> phasestep=0 and cmd_ready=0 during reset, no done, phase_o=0, cmd_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/ecp5pll_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic-phase controller.
package ecp5pll_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_GAP,
      ST_LOCKWAIT,
      ST_DONE
   } state_t;

   typedef logic [1:0] chan_t;

   localparam int ACC_W   = 10;
   localparam int NUM_CH  = 4;
   localparam int TIMER_W = 8;
   localparam int STEPS_W = 8;

   localparam int DEF_SETUP_CYC = 4;
   localparam int DEF_PULSE_CYC = 4;
   localparam int DEF_GAP_CYC   = 8;
   localparam bit DEF_LOCK_WAIT = 1'b1;

   // One phase step; the accumulator width makes the wrap modulo 1024.
   function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc, input logic dir);
      return dir ? acc - 1'b1 : acc + 1'b1;
   endfunction

endpackage

// File: rtl/ecp5pll_phase_ctrl_if.sv
// Command handshake bundle for the dynamic-phase controller.
interface ecp5pll_phase_ctrl_if;
   import ecp5pll_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   chan_t               cmd_sel;
   logic                cmd_dir;
   logic                cmd_load;
   logic [STEPS_W-1:0]  cmd_steps;

   modport master (
      output cmd_valid, cmd_sel, cmd_dir, cmd_load, cmd_steps,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_sel, cmd_dir, cmd_load, cmd_steps,
      output cmd_ready
   );

endinterface

// File: rtl/ecp5pll_pulse_timer.sv
// Loadable down-counter; zero is high once the loaded count has run out.
module ecp5pll_pulse_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequences phasestep/phaseloadreg pulses on the ECP5 PLL dynamic-phase pins
// and keeps a per-channel step accumulator.
module ecp5pll_phase_ctrl
   import ecp5pll_pkg::*;
#(
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int PULSE_CYC = DEF_PULSE_CYC,
   parameter int GAP_CYC   = DEF_GAP_CYC,
   parameter bit LOCK_WAIT = DEF_LOCK_WAIT
) (
   input  logic                    clk_i,
   input  logic                    reset,
   ecp5pll_phase_ctrl_if.slave     cmd,
   input  logic                    locked,
   output chan_t                   phasesel,
   output logic                    phasedir,
   output logic                    phasestep,
   output logic                    phaseloadreg,
   output logic                    busy,
   output logic                    done,
   output logic [NUM_CH*ACC_W-1:0] phase_o
);

   // Timer is loaded with length-1 so it reads zero in the last cycle of an interval.
   localparam logic [TIMER_W-1:0] SETUP_V = TIMER_W'(SETUP_CYC - 1);
   localparam logic [TIMER_W-1:0] PULSE_V = TIMER_W'(PULSE_CYC - 1);
   localparam logic [TIMER_W-1:0] GAP_V   = TIMER_W'(GAP_CYC - 1);

   state_t              state, state_next;
   chan_t               sel_q;
   logic                dir_q;
   logic                load_q;
   logic [STEPS_W-1:0]  rem_q;
   logic [ACC_W-1:0]    acc [NUM_CH];

   logic                accept;
   logic                want_pulse;
   logic                enter_pulse;
   logic                rem_dec;
   logic                tmr_load;
   logic [TIMER_W-1:0]  tmr_val;
   logic                tmr_zero;

   ecp5pll_pulse_timer #(.W(TIMER_W)) u_timer (
      .clk_i    (clk_i),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      want_pulse  = 1'b0;
      enter_pulse = 1'b0;
      rem_dec     = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      case (state)
         ST_IDLE: begin
            if (cmd.cmd_valid) begin
               accept = 1'b1;
               if (!cmd.cmd_load && cmd.cmd_steps == '0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_SETUP;
                  tmr_load   = 1'b1;
                  tmr_val    = SETUP_V;
               end
            end
         end
         ST_SETUP: begin
            if (tmr_zero) want_pulse = 1'b1;
         end
         // Re-evaluated every cycle; the lock check below keeps us here until locked.
         ST_LOCKWAIT: want_pulse = 1'b1;
         ST_PULSE: begin
            if (tmr_zero) begin
               state_next = ST_GAP;
               tmr_load   = 1'b1;
               tmr_val    = GAP_V;
            end
         end
         ST_GAP: begin
            if (tmr_zero) begin
               if (load_q || rem_q == STEPS_W'(1)) begin
                  state_next = ST_DONE;
               end else begin
                  rem_dec    = 1'b1;
                  want_pulse = 1'b1;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      // Lock is only consulted before a pulse starts, so a running pulse is never cut short.
      if (want_pulse) begin
         if (LOCK_WAIT && !locked) begin
            state_next = ST_LOCKWAIT;
         end else begin
            state_next  = ST_PULSE;
            enter_pulse = 1'b1;
            tmr_load    = 1'b1;
            tmr_val     = PULSE_V;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state  <= ST_IDLE;
         sel_q  <= '0;
         dir_q  <= 1'b0;
         load_q <= 1'b0;
         rem_q  <= '0;
         for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            sel_q  <= cmd.cmd_sel;
            dir_q  <= cmd.cmd_dir;
            load_q <= cmd.cmd_load;
            rem_q  <= cmd.cmd_steps;
         end else if (rem_dec) begin
            rem_q <= rem_q - 1'b1;
         end
         if (enter_pulse) begin
            acc[sel_q] <= load_q ? '0 : acc_step(acc[sel_q], dir_q);
         end
      end
   end

   always_comb begin
      phase_o = '0;
      for (int k = 0; k < NUM_CH; k++) phase_o[k*ACC_W +: ACC_W] = acc[k];
   end

   // cmd_ready is gated by reset so it reads 0 for the whole reset window.
   assign cmd.cmd_ready  = (state == ST_IDLE) && !reset;
   assign busy           = (state != ST_IDLE);
   assign done           = (state == ST_DONE);
   assign phasestep      = (state == ST_PULSE) && !load_q;
   assign phaseloadreg   = (state == ST_PULSE) && load_q;
   assign phasesel       = sel_q;
   assign phasedir       = dir_q;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Randomized scoreboard bench for ecp5pll_phase_ctrl against a timing/accumulator model.
module tb_ecp5pll_phase_ctrl;
   import ecp5pll_pkg::*;

   localparam int SETUP = 4;
   localparam int PULSE = 4;
   localparam int GAP   = 8;
   localparam int PER   = PULSE + GAP;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        locked = 1'b1;
   chan_t       phasesel;
   logic        phasedir, phasestep, phaseloadreg, busy, done;
   logic [39:0] phase_o;

   ecp5pll_phase_ctrl_if cmd_if ();

   ecp5pll_phase_ctrl #(
      .SETUP_CYC (SETUP),
      .PULSE_CYC (PULSE),
      .GAP_CYC   (GAP),
      .LOCK_WAIT (1'b1)
   ) dut (
      .clk_i        (clk),
      .reset        (reset),
      .cmd          (cmd_if),
      .locked       (locked),
      .phasesel     (phasesel),
      .phasedir     (phasedir),
      .phasestep    (phasestep),
      .phaseloadreg (phaseloadreg),
      .busy         (busy),
      .done         (done),
      .phase_o      (phase_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      int          dir;
      int          load;
      int          npulse;
      int          stall;
      int          done_t;
      logic [39:0] phase;
   } exp_t;

   exp_t sbq[$];
   int   model_acc[4];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [39:0] model_phase();
      logic [39:0] p;
      for (int k = 0; k < 4; k++) p[k*10 +: 10] = 10'(model_acc[k]);
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, req, $time);
      end
   endtask

   // Called at posedge+1; holds reset for cyc edges.
   task automatic do_reset(input int cyc);
      reset = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      locked = 1'b1;
      repeat (cyc) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) model_acc[k] = 0;
   endtask

   task automatic issue(input int sel, input int dir, input int load, input int steps,
                        input int stall_in, input bit hold);
      exp_t e;
      int   w;
      int   stall;
      w = 0;
      while (cmd_if.cmd_ready !== 1'b1) begin
         @(posedge clk); #1;
         w++;
         if (w > 8000) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: cmd_ready=%b, expected 1", cmd_if.cmd_ready);
            return;
         end
      end
      e.sel  = sel;
      e.dir  = dir;
      e.load = load;
      if (load != 0) begin
         e.npulse = 1;
         model_acc[sel] = 0;
      end else begin
         e.npulse = steps;
         model_acc[sel] = ((model_acc[sel] + (dir != 0 ? -steps : steps)) % 1024 + 1024) % 1024;
      end
      stall   = (e.npulse == 0) ? 0 : stall_in;
      e.stall = stall;
      e.done_t = (e.npulse == 0) ? 1 : SETUP + e.npulse * PER + 1 + stall;
      e.phase  = model_phase();
      sbq.push_back(e);

      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_sel   = 2'(sel);
      cmd_if.cmd_dir   = 1'(dir);
      cmd_if.cmd_load  = 1'(load);
      cmd_if.cmd_steps = 8'(steps);
      if (stall > 0) locked = 1'b0;
      @(posedge clk); #1;
      if (!hold) begin
         cmd_if.cmd_valid = 1'b0;
         cmd_if.cmd_sel   = 2'($urandom);
         cmd_if.cmd_dir   = 1'($urandom);
         cmd_if.cmd_load  = 1'($urandom);
         cmd_if.cmd_steps = 8'($urandom);
      end
      // Now in cycle 1; raise locked so it is high during cycle SETUP+stall.
      if (stall > 0) begin
         repeat (SETUP + stall - 1) @(posedge clk);
         #1;
         locked = 1'b1;
      end
      if (hold) begin
         w = 0;
         while (done !== 1'b1 && w < 8000) begin
            @(posedge clk); #1;
            w++;
         end
         if (w >= 8000) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: done=%b, expected 1", done);
         end
         @(posedge clk); #1;
         cmd_if.cmd_valid = 1'b0;
      end
   endtask

   // Monitor: t counts cycles since the accepting edge.
   int t = -1;
   bit prev_rst = 1'b0;

   always @(negedge clk) begin
      exp_t       e;
      int         rel;
      logic       in_p;
      logic [6:0] act_v, req_v;
      if (t >= 0) t++;
      act_v = {phasesel, phasedir, phasestep, phaseloadreg, busy, done, cmd_if.cmd_ready};
      if (reset) begin
         if (prev_rst) begin
            check("reset_outputs", 64'(act_v), 64'(0));
            check("reset_phase", 64'(phase_o), 64'(0));
            sbq.delete();
            t = -1;
         end
      end else if (t >= 1) begin
         if (sbq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL no_expectation: busy=%b done=%b, expected no command in flight", busy, done);
            t = -1;
         end else begin
            e    = sbq[0];
            rel  = t - (SETUP + 1 + e.stall);
            in_p = (e.npulse > 0) && (rel >= 0) && (rel / PER < e.npulse) && (rel % PER < PULSE);
            req_v = {2'(e.sel), 1'(e.dir), in_p && (e.load == 0), in_p && (e.load != 0),
                     1'b1, (t == e.done_t), 1'b0};
            check($sformatf("ctl_cycle%0d", t), 64'(act_v), 64'(req_v));
            if (t == e.done_t) begin
               check("phase_o", 64'(phase_o), 64'(e.phase));
               void'(sbq.pop_front());
               t = -1;
            end
         end
      end else begin
         check("idle", 64'({phasestep, phaseloadreg, busy, done, cmd_if.cmd_ready}), 64'(5'b00001));
      end
      if (!reset && t == -1 && cmd_if.cmd_valid && cmd_if.cmd_ready) t = 0;
      prev_rst = reset;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   int r_sel, r_dir, r_ld, r_st, r_sl, r_gap, r_w;
   bit r_hold;

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_sel   = '0;
      cmd_if.cmd_dir   = 1'b0;
      cmd_if.cmd_load  = 1'b0;
      cmd_if.cmd_steps = '0;
      for (int k = 0; k < 4; k++) model_acc[k] = 0;
      do_reset(3);

      // Directed scenarios
      issue(2, 0, 0, 3, 0, 1'b0);
      issue(1, 1, 0, 1, 0, 1'b0);
      issue(1, 0, 0, 2, 0, 1'b0);
      issue(1, 1, 1, 7, 0, 1'b0);
      issue(3, 0, 0, 0, 0, 1'b0);
      issue(0, 0, 0, 1, 16, 1'b0);
      issue(3, 1, 0, 2, 0, 1'b1);
      issue(0, 0, 0, 3, 0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      do_reset(3);

      for (int i = 0; i < 60; i++) begin
         r_sel  = $urandom_range(0, 3);
         r_dir  = $urandom_range(0, 1);
         r_ld   = ($urandom_range(0, 5) == 0) ? 1 : 0;
         r_st   = ($urandom_range(0, 24) == 0) ? 255 : $urandom_range(0, 5);
         r_sl   = (r_ld == 0 && r_st != 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 10) : 0;
         r_hold = ($urandom_range(0, 5) == 0);
         r_gap  = $urandom_range(0, 3);
         repeat (r_gap) begin @(posedge clk); #1; end
         issue(r_sel, r_dir, r_ld, r_st, r_sl, r_hold);
         if ($urandom_range(0, 14) == 0) begin
            r_gap = $urandom_range(1, 30);
            repeat (r_gap) begin @(posedge clk); #1; end
            do_reset(2);
         end
      end

      r_w = 0;
      while (sbq.size() != 0 && r_w < 8000) begin
         @(posedge clk); #1;
         r_w++;
      end
      if (sbq.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: %0d commands outstanding, expected 0", sbq.size());
      end
      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
